// File: rtl/div_result_bcd_if.sv
// Handshake bundle between the divider, the BCD formatter and the display/report stage.
// master = upstream/downstream environment, slave = the formatter itself.
interface div_result_bcd_if #(
   parameter int DW = 4,
   parameter int ND = 2
);
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_quo;
   logic [DW-1:0]   in_rem;
   logic            in_dbz;
   logic            out_valid;
   logic            out_ready;
   logic [4*ND-1:0] out_quo_bcd;
   logic [4*ND-1:0] out_rem_bcd;
   logic            out_err;
   logic            busy;

   modport master (
      output in_valid, in_quo, in_rem, in_dbz, out_ready,
      input  in_ready, out_valid, out_quo_bcd, out_rem_bcd, out_err, busy
   );

   modport slave (
      input  in_valid, in_quo, in_rem, in_dbz, out_ready,
      output in_ready, out_valid, out_quo_bcd, out_rem_bcd, out_err, busy
   );
endinterface

// File: rtl/div_result_bcd.sv
// Iterative double-dabble formatter turning a divider quotient/remainder into packed BCD.
// Define DIV_RESULT_BCD_DBZ_EN to flag divide-by-zero results instead of converting them.
module div_result_bcd #(
   parameter int DW = 4,
   parameter int ND = 2
) (
   input logic             clk,
   input logic             rst,
   div_result_bcd_if.slave bus
);
   localparam int BW = 4 * ND;
   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] quo_bin;
   logic [DW-1:0] rem_bin;
   logic [BW-1:0] quo_bcd;
   logic [BW-1:0] rem_bcd;
   logic [BW-1:0] quo_shift;
   logic [BW-1:0] rem_shift;
   logic [BW-1:0] quo_out;
   logic [BW-1:0] rem_out;
   logic [CW-1:0] count;
   logic          accept;
   logic          take_dbz;
   logic          last_iter;

   // Digits of 5 or more would become >= 10 after doubling, so pre-correct them.
   function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      r = v;
      for (int d = 0; d < ND; d++) begin
         if (v[4*d +: 4] >= 4'd5) begin
            r[4*d +: 4] = v[4*d +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   assign accept    = (state == IDLE) && bus.in_valid;
   assign last_iter = (count == CW'(1));
   assign quo_shift = BW'({add3(quo_bcd), quo_bin[DW-1]});
   assign rem_shift = BW'({add3(rem_bcd), rem_bin[DW-1]});

`ifdef DIV_RESULT_BCD_DBZ_EN
   logic err_out;

   assign take_dbz = accept && bus.in_dbz;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_out <= 1'b0;
      end else if (take_dbz) begin
         err_out <= 1'b1;
      end else if (state == CONV && last_iter) begin
         err_out <= 1'b0;
      end
   end

   assign bus.out_err = err_out;
`else
   logic unused_dbz;

   assign unused_dbz  = bus.in_dbz;
   assign take_dbz    = 1'b0;
   assign bus.out_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = take_dbz ? HOLD : CONV;
            end
         end
         CONV: begin
            if (last_iter) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // in_ready is masked by rst so upstream never sees a handshake that reset would discard.
   always_comb begin
      bus.in_ready  = (state == IDLE) && !rst;
      bus.busy      = (state == CONV);
      bus.out_valid = (state == HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quo_bin <= '0;
         rem_bin <= '0;
         quo_bcd <= '0;
         rem_bcd <= '0;
         quo_out <= '0;
         rem_out <= '0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  quo_bin <= bus.in_quo;
                  rem_bin <= bus.in_rem;
                  quo_bcd <= '0;
                  rem_bcd <= '0;
                  count   <= CW'(DW);
                  if (take_dbz) begin
                     quo_out <= '1;
                     rem_out <= '1;
                  end
               end
            end
            CONV: begin
               quo_bcd <= quo_shift;
               rem_bcd <= rem_shift;
               quo_bin <= quo_bin << 1;
               rem_bin <= rem_bin << 1;
               count   <= count - CW'(1);
               if (last_iter) begin
                  quo_out <= quo_shift;
                  rem_out <= rem_shift;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.out_quo_bcd = quo_out;
   assign bus.out_rem_bcd = rem_out;
endmodule

// File: tb/tb_div_result_bcd.sv
// Randomized scoreboard bench for div_result_bcd; expectations come from decimal arithmetic.
// Build with or without DIV_RESULT_BCD_DBZ_EN to match the RTL configuration.
module tb_div_result_bcd;
   localparam int DW = 4;
   localparam int ND = 2;
   localparam int BW = 4 * ND;

   typedef struct {
      logic [BW-1:0] quo;
      logic [BW-1:0] rem;
      logic          err;
      int            acceptCycle;
      int            latency;
   } expect_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   div_result_bcd_if #(.DW(DW), .ND(ND)) bus ();

   div_result_bcd #(.DW(DW), .ND(ND)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   expect_t sb[$];
   int      vectorCount = 0;
   int      missCount = 0;
   int      cycleCount = 0;
   bit      randomBackpressure = 1'b0;
   bit      prevValid = 1'b0;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   function automatic logic [BW-1:0] toBcd(input int v);
      logic [BW-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int d = 0; d < ND; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Presents one pair, waits for acceptance and records what the display stage must later see.
   task automatic applyStimulus(input int quo, input int rem, input bit dbz, output int acceptCycle);
      expect_t e;
      int waitCycles;
      waitCycles = 0;
      bus.in_valid = 1'b1;
      bus.in_quo   = DW'(quo);
      bus.in_rem   = DW'(rem);
      bus.in_dbz   = dbz;
      @(negedge clk);
      while (!bus.in_ready && waitCycles < 100) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!bus.in_ready) begin
         vectorCount++;
         missCount++;
         $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
         acceptCycle = -1;
      end else begin
         acceptCycle = cycleCount;
         e.acceptCycle = cycleCount;
`ifdef DIV_RESULT_BCD_DBZ_EN
         if (dbz) begin
            e.quo     = '1;
            e.rem     = '1;
            e.err     = 1'b1;
            e.latency = 1;
         end else
`endif
         begin
            e.quo     = toBcd(quo);
            e.rem     = toBcd(rem);
            e.err     = 1'b0;
            e.latency = DW + 1;
         end
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain(input int limit);
      int n;
      n = 0;
      while ((sb.size() != 0 || !bus.in_ready) && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain_pending", 32'(sb.size()), 0);
   endtask

   always @(posedge clk) begin
      #1;
      if (randomBackpressure) bus.out_ready = ($urandom_range(2) != 0);
   end

   // Monitor: every HOLD cycle must show the oldest outstanding result; a handshake retires it.
   always @(negedge clk) begin
      if (rst) begin
         prevValid = 1'b0;
      end else begin
         if (bus.out_valid) begin
            checkOutput("in_ready_in_hold", 32'(bus.in_ready), 0);
            if (sb.size() == 0) begin
               vectorCount++;
               missCount++;
               $display("[TB] FAIL unexpected_result: out_valid=1 with no outstanding transaction, expected 0");
            end else begin
               if (!prevValid) begin
                  checkOutput("latency", 32'(cycleCount - sb[0].acceptCycle), 32'(sb[0].latency));
               end
               checkOutput("quo_bcd", 32'(bus.out_quo_bcd), 32'(sb[0].quo));
               checkOutput("rem_bcd", 32'(bus.out_rem_bcd), 32'(sb[0].rem));
               checkOutput("err", 32'(bus.out_err), 32'(sb[0].err));
               if (bus.out_ready) void'(sb.pop_front());
            end
         end
         prevValid = bus.out_valid && !bus.out_ready;
      end
   end

   initial begin
      int t;
      int prevT;
      int n;
      bus.in_valid  = 1'b0;
      bus.in_quo    = '0;
      bus.in_rem    = '0;
      bus.in_dbz    = 1'b0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
      checkOutput("rst_quo", 32'(bus.out_quo_bcd), 0);
      checkOutput("rst_rem", 32'(bus.out_rem_bcd), 0);
      checkOutput("rst_err", 32'(bus.out_err), 0);
      checkOutput("rst_busy", 32'(bus.busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("in_ready_after_rst", 32'(bus.in_ready), 1);
      @(posedge clk);
      #1;

      // 10/3 with downstream always ready, busy tracked through the conversion.
      bus.out_ready = 1'b1;
      applyStimulus(3, 1, 1'b0, t);
      bus.in_valid = 1'b0;
      for (int i = 0; i < DW; i++) begin
         @(negedge clk);
         checkOutput("busy_conv", 32'(bus.busy), 1);
         checkOutput("valid_conv", 32'(bus.out_valid), 0);
      end
      @(negedge clk);
      checkOutput("busy_hold", 32'(bus.busy), 0);
      checkOutput("valid_hold", 32'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      applyStimulus(15, 0, 1'b0, t);
      bus.in_valid = 1'b0;
      waitDrain(30);
      applyStimulus(2, 1, 1'b0, t);
      bus.in_valid = 1'b0;
      waitDrain(30);

      // Backpressure in HOLD.
      bus.out_ready = 1'b0;
      applyStimulus(7, 2, 1'b0, t);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("hold_reached", 32'(bus.out_valid), 1);
      repeat (3) begin
         @(negedge clk);
         checkOutput("hold_valid", 32'(bus.out_valid), 1);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("release_valid", 32'(bus.out_valid), 0);
      checkOutput("release_in_ready", 32'(bus.in_ready), 1);
      @(posedge clk);
      #1;

      applyStimulus(5, 3, 1'b1, t);
      bus.in_valid = 1'b0;
      waitDrain(30);

      // Reset during the second conversion cycle discards the transaction.
      applyStimulus(9, 4, 1'b0, t);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      @(negedge clk);
      checkOutput("abort_valid", 32'(bus.out_valid), 0);
      checkOutput("abort_quo", 32'(bus.out_quo_bcd), 0);
      checkOutput("abort_rem", 32'(bus.out_rem_bcd), 0);
      checkOutput("abort_err", 32'(bus.out_err), 0);
      checkOutput("abort_busy", 32'(bus.busy), 0);
      checkOutput("abort_in_ready", 32'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      applyStimulus(2, 0, 1'b0, t);
      bus.in_valid = 1'b0;
      waitDrain(30);

      // in_valid held high with fresh data: one acceptance every DW+2 cycles.
      prevT = -1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(int'($urandom_range(15)), int'($urandom_range(15)), 1'b0, t);
         if (i > 0) checkOutput("accept_spacing", 32'(t - prevT), DW + 2);
         prevT = t;
      end
      bus.in_valid = 1'b0;
      waitDrain(50);

      // Random data, random divide-by-zero and random downstream stalls.
      randomBackpressure = 1'b1;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(int'($urandom_range(15)), int'($urandom_range(15)), ($urandom_range(3) == 0), t);
         bus.in_valid = 1'($urandom_range(1));
         if (!bus.in_valid) begin
            repeat ($urandom_range(2)) @(posedge clk);
         end
      end
      bus.in_valid = 1'b0;
      randomBackpressure = 1'b0;
      @(posedge clk);
      #2 bus.out_ready = 1'b1;
      waitDrain(100);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
